// File: rtl/mskrnd_xs32_src_pkg.sv
// mskrnd_xs32_src_pkg
// Shared constants and helpers for the xorshift32 randomness source that
// feeds the rnd buses of masked HPC2 gadgets.
//   - hpc2rnd(d): fresh random bits one HPC2 AND gadget consumes per cycle
//   - XS_SH_A/B/C: xorshift32 shift amounts (13, 17, 5)
//   - ZERO_SEED_SUB: stands in for an all-zero seed word, because zero is
//     the xorshift fixed point and would give an all-zero stream forever
//   - ST_*: controller state encodings
package mskrnd_xs32_src_pkg;

    localparam int XS_SH_A = 13;
    localparam int XS_SH_B = 17;
    localparam int XS_SH_C = 5;

    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    localparam logic [1:0] ST_UNSEEDED = 2'd0;
    localparam logic [1:0] ST_SEEDING  = 2'd1;
    localparam logic [1:0] ST_WARMUP   = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    function automatic int hpc2rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    function automatic logic [31:0] xs32_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << XS_SH_A);
        t = t ^ (t >> XS_SH_B);
        t = t ^ (t << XS_SH_C);
        return t;
    endfunction

endpackage

// File: rtl/mskrnd_xs32_src_lane.sv
// rnd_xs32_lane
// One 32-bit xorshift32 lane register.
// Ports:
//   clk, rst   clock, synchronous active-high reset (lane clears to 0)
//   load       load seed (zero seed replaced by ZERO_SEED_SUB); wins over step
//   step       advance one xorshift32 step
//   seed       seed word
//   q          current lane value
module rnd_xs32_lane
    import mskrnd_xs32_src_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 32'd0;
        end else if (load) begin
            q <= (seed == 32'd0) ? ZERO_SEED_SUB : seed;
        end else if (step) begin
            q <= xs32_step(q);
        end
    end

endmodule

// File: rtl/mskrnd_xs32_src.sv
// mskrnd_xs32_src
// Fresh-randomness source for masked HPC2 gadgets. NLANES xorshift32 lanes
// are seeded one word per lane, stepped WARMUP times, then advanced once per
// accepted rnd transfer.
// Parameters: d (shares), NGADGETS, WARMUP; RND_W and NLANES are derived.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   seed_valid/seed_ready/seed_data  seed word interface (lane idx order)
//   rnd_valid/rnd_ready/rnd          random word interface
//   reseed_req                       only with MSKRND_RESEED_REQ_EN: raised
//                                    after RESEED_PERIOD transfers since the
//                                    last seed transfer
// Optional feature macro: MSKRND_RESEED_REQ_EN (adds RESEED_PERIOD, reseed_req).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. seed_ready depends only on state (low only during warm-up);
// rnd_valid depends only on state (high only in RUN). Neither ready nor valid
// is combinationally derived from the other side.
module mskrnd_xs32_src
    import mskrnd_xs32_src_pkg::*;
#(
    parameter  int d        = 2,
    parameter  int NGADGETS = 8,
`ifdef MSKRND_RESEED_REQ_EN
    parameter  int RESEED_PERIOD = 1024,
`endif
    parameter  int WARMUP   = 16,
    localparam int RND_W    = NGADGETS * hpc2rnd(d),
    localparam int NLANES   = (RND_W + 31) / 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [31:0]      seed_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [RND_W-1:0] rnd
`ifdef MSKRND_RESEED_REQ_EN
    ,
    output logic             reseed_req
`endif
);

    localparam int IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [31:0]          wcnt;
    logic [NLANES*32-1:0] lane_bus;

    logic seed_fire;
    logic rnd_fire;
    logic lane_step;
    logic last_lane;

    assign seed_ready = (state != ST_WARMUP);
    assign rnd_valid  = (state == ST_RUN);
    assign seed_fire  = seed_valid & seed_ready;
    // A reseed in RUN takes priority: the current word is not consumed.
    assign rnd_fire   = rnd_valid & rnd_ready & ~seed_fire;
    assign lane_step  = (state == ST_WARMUP) | rnd_fire;
    assign last_lane  = (idx == IDX_W'(NLANES - 1));

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        rnd_xs32_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (seed_fire && (idx == IDX_W'(i))),
            .step (lane_step),
            .seed (seed_data),
            .q    (lane_bus[i*32 +: 32])
        );
    end

    assign rnd = lane_bus[RND_W-1:0];

    // Top-lane bits beyond RND_W keep stepping but never leave the block.
    logic unused_lane_bits;
    assign unused_lane_bits = ^lane_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_UNSEEDED;
            idx   <= '0;
            wcnt  <= 32'd0;
        end else begin
            if (seed_fire) begin
                // Same path from UNSEEDED, SEEDING and RUN; in RUN idx is 0,
                // so a reseed restarts at lane 0.
                if (last_lane) begin
                    idx <= '0;
                    if (WARMUP == 0) begin
                        state <= ST_RUN;
                    end else begin
                        state <= ST_WARMUP;
                        wcnt  <= 32'(WARMUP);
                    end
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_SEEDING;
                end
            end else if (state == ST_WARMUP) begin
                wcnt <= wcnt - 32'd1;
                if (wcnt == 32'd1) begin
                    state <= ST_RUN;
                end
            end
        end
    end

`ifdef MSKRND_RESEED_REQ_EN
    logic [31:0] xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt   <= 32'd0;
            reseed_req <= 1'b0;
        end else if (seed_fire) begin
            xfer_cnt   <= 32'd0;
            reseed_req <= 1'b0;
        end else if (rnd_fire) begin
            xfer_cnt <= xfer_cnt + 32'd1;
            if (xfer_cnt == 32'(RESEED_PERIOD - 1)) begin
                reseed_req <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mskrnd_xs32_src.sv
// tb_mskrnd_xs32_src
// Three instances: A (d=3, NGADGETS=8, WARMUP=0: 24-bit, one lane),
// B (defaults: 8-bit, one lane, WARMUP=16) and C (d=3, NGADGETS=16,
// WARMUP=3: 48-bit, two lanes). Expected words come from a plain
// xorshift32 model of each lane. With MSKRND_RESEED_REQ_EN defined,
// instance A uses RESEED_PERIOD=4.
module tb_mskrnd_xs32_src;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst_a, sv_a, rr_a, sr_a, vld_a;
    logic [31:0] sd_a;
    logic [23:0] rnd_a;
    logic        rst_b, sv_b, rr_b, sr_b, vld_b;
    logic [31:0] sd_b;
    logic [7:0]  rnd_b;
    logic        rst_c, sv_c, rr_c, sr_c, vld_c;
    logic [31:0] sd_c;
    logic [47:0] rnd_c;
`ifdef MSKRND_RESEED_REQ_EN
    logic        req_a, req_b, req_c;
`endif

    mskrnd_xs32_src #(
        .d(3), .NGADGETS(8),
`ifdef MSKRND_RESEED_REQ_EN
        .RESEED_PERIOD(4),
`endif
        .WARMUP(0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .seed_valid(sv_a), .seed_ready(sr_a),
        .seed_data(sd_a), .rnd_valid(vld_a), .rnd_ready(rr_a), .rnd(rnd_a)
`ifdef MSKRND_RESEED_REQ_EN
        , .reseed_req(req_a)
`endif
    );

    mskrnd_xs32_src dut_b (
        .clk(clk), .rst(rst_b), .seed_valid(sv_b), .seed_ready(sr_b),
        .seed_data(sd_b), .rnd_valid(vld_b), .rnd_ready(rr_b), .rnd(rnd_b)
`ifdef MSKRND_RESEED_REQ_EN
        , .reseed_req(req_b)
`endif
    );

    mskrnd_xs32_src #(.d(3), .NGADGETS(16), .WARMUP(3)) dut_c (
        .clk(clk), .rst(rst_c), .seed_valid(sv_c), .seed_ready(sr_c),
        .seed_data(sd_c), .rnd_valid(vld_c), .rnd_ready(rr_c), .rnd(rnd_c)
`ifdef MSKRND_RESEED_REQ_EN
        , .reseed_req(req_c)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] seed_val(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    logic [31:0] ma, mb;
    logic [31:0] mc[2];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Count edges until B raises rnd_valid; seed_ready must stay low meanwhile.
    task automatic wait_b(output int cyc);
        cyc = 0;
        while (!vld_b && cyc < 40) begin
            check_eq("b_seed_ready_warm", 64'(sr_b), 64'd0);
            sd_b = $urandom;
            tick();
            cyc++;
        end
        sv_b = 1'b0;
    endtask

    task automatic wait_c(output int cyc);
        cyc = 0;
        while (!vld_c && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // One seed word into C after a random idle gap; optional concurrent rnd_ready.
    task automatic seed_c(input logic [31:0] w, input logic with_ready);
        repeat ($urandom_range(0, 2)) tick();
        sv_c = 1'b1;
        sd_c = w;
        rr_c = with_ready;
        tick();
        sv_c = 1'b0;
        rr_c = 1'b0;
    endtask

    function automatic logic [47:0] exp_c();
        logic [63:0] cat;
        cat = {mc[1], mc[0]};
        return cat[47:0];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic [31:0] s;

        {sv_a, rr_a, sv_b, rr_b, sv_c, rr_c} = '0;
        sd_a = '0; sd_b = '0; sd_c = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // ---- A: reset state ----
        check_eq("a_rst_valid", 64'(vld_a), 64'd0);
        check_eq("a_rst_ready", 64'(sr_a), 64'd1);
        check_eq("a_rst_rnd", 64'(rnd_a), 64'd0);

        // ---- A: seed 1, WARMUP=0 ----
        sv_a = 1'b1; sd_a = 32'h1;
        tick();
        sv_a = 1'b0;
        ma = seed_val(32'h1);
        check_eq("a_seed1_valid", 64'(vld_a), 64'd1);
        check_eq("a_seed1_rnd", 64'(rnd_a), 64'h000001);
        rr_a = 1'b1;
        tick();
        rr_a = 1'b0;
        ma = xs32(ma);
        check_eq("a_first_xfer", 64'(rnd_a), 64'h042021);

        // ---- A: backpressure ----
        repeat (5) begin
            tick();
            check_eq("a_bp_rnd", 64'(rnd_a), 64'h042021);
            check_eq("a_bp_valid", 64'(vld_a), 64'd1);
        end

        // ---- A: random ready ----
        for (int i = 0; i < 60; i++) begin
            rr_a = 1'($urandom_range(0, 1));
            tick();
            if (rr_a) ma = xs32(ma);
            check_eq("a_run_rnd", 64'(rnd_a), 64'(ma[23:0]));
            check_eq("a_run_valid", 64'(vld_a), 64'd1);
        end
        rr_a = 1'b0;

        // ---- A: zero seed behaves like seed 1 ----
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check_eq("a_rst2_rnd", 64'(rnd_a), 64'd0);
        sv_a = 1'b1; sd_a = 32'h0;
        tick();
        sv_a = 1'b0;
        ma = 32'h1;
        check_eq("a_seed0_rnd", 64'(rnd_a), 64'(ma[23:0]));
        rr_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            ma = xs32(ma);
            check_eq("a_seed0_seq", 64'(rnd_a), 64'(ma[23:0]));
        end

        // ---- A: reseed in RUN wins over rnd_ready ----
        s = $urandom;
        sv_a = 1'b1; sd_a = s; rr_a = 1'b1;
        tick();
        sv_a = 1'b0; rr_a = 1'b0;
        ma = seed_val(s);
        check_eq("a_reseed_rnd", 64'(rnd_a), 64'(ma[23:0]));

`ifdef MSKRND_RESEED_REQ_EN
        // ---- A: reseed request after 4 transfers ----
        check_eq("a_req_after_seed", 64'(req_a), 64'd0);
        for (int k = 1; k <= 6; k++) begin
            rr_a = 1'b1;
            tick();
            check_eq("a_req_count", 64'(req_a), (k >= 4) ? 64'd1 : 64'd0);
        end
        rr_a = 1'b0;
        check_eq("a_req_flowing", 64'(vld_a), 64'd1);
        sv_a = 1'b1; sd_a = $urandom;
        tick();
        sv_a = 1'b0;
        check_eq("a_req_clear", 64'(req_a), 64'd0);
`endif

        // ---- B: reset state, default params ----
        check_eq("b_rst_valid", 64'(vld_b), 64'd0);
        check_eq("b_rst_ready", 64'(sr_b), 64'd1);
        check_eq("b_rst_rnd", 64'(rnd_b), 64'd0);

        // ---- B: seed then 16 warm-up cycles, seed_valid held high ----
        s = $urandom;
        sv_b = 1'b1; sd_b = s;
        tick();
        mb = seed_val(s);
        wait_b(cyc);
        check_eq("b_warmup_cycles", 64'(cyc), 64'd16);
        for (int i = 0; i < 16; i++) mb = xs32(mb);
        check_eq("b_after_warm", 64'(rnd_b), 64'(mb[7:0]));
        for (int i = 0; i < 20; i++) begin
            rr_b = 1'($urandom_range(0, 1));
            tick();
            if (rr_b) mb = xs32(mb);
            check_eq("b_run_rnd", 64'(rnd_b), 64'(mb[7:0]));
        end

        // ---- B: reseed with simultaneous rnd_ready ----
        s = $urandom;
        sv_b = 1'b1; sd_b = s; rr_b = 1'b1;
        tick();
        sv_b = 1'b0; rr_b = 1'b0;
        mb = seed_val(s);
        check_eq("b_reseed_valid", 64'(vld_b), 64'd0);
        check_eq("b_reseed_rnd", 64'(rnd_b), 64'(mb[7:0]));
        wait_b(cyc);
        check_eq("b_rewarm_cycles", 64'(cyc), 64'd16);
        for (int i = 0; i < 16; i++) mb = xs32(mb);
        check_eq("b_rewarm_rnd", 64'(rnd_b), 64'(mb[7:0]));

        // ---- B: reset mid-warmup ----
        sv_b = 1'b1; sd_b = $urandom;
        tick();
        sv_b = 1'b0;
        repeat (5) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check_eq("b_midrst_valid", 64'(vld_b), 64'd0);
        check_eq("b_midrst_ready", 64'(sr_b), 64'd1);
        check_eq("b_midrst_rnd", 64'(rnd_b), 64'd0);
        repeat (20) tick();
        check_eq("b_stays_unseeded", 64'(vld_b), 64'd0);

        // ---- C: two-lane seeding ----
        check_eq("c_rst_rnd", 64'(rnd_c), 64'd0);
        s = $urandom;
        seed_c(s, 1'b0);
        mc[0] = seed_val(s);
        check_eq("c_mid_seed_valid", 64'(vld_c), 64'd0);
        check_eq("c_mid_seed_ready", 64'(sr_c), 64'd1);
        s = 32'h0;
        seed_c(s, 1'b0);
        mc[1] = seed_val(s);
        wait_c(cyc);
        check_eq("c_warmup_cycles", 64'(cyc), 64'd3);
        for (int i = 0; i < 3; i++) begin
            mc[0] = xs32(mc[0]);
            mc[1] = xs32(mc[1]);
        end
        check_eq("c_after_warm", 64'(rnd_c), 64'(exp_c()));
        for (int i = 0; i < 40; i++) begin
            rr_c = 1'($urandom_range(0, 1));
            tick();
            if (rr_c) begin
                mc[0] = xs32(mc[0]);
                mc[1] = xs32(mc[1]);
            end
            check_eq("c_run_rnd", 64'(rnd_c), 64'(exp_c()));
        end
        rr_c = 1'b0;

        // ---- C: reseed in RUN, lane 0 first, lane 1 held ----
        s = $urandom;
        seed_c(s, 1'b1);
        mc[0] = seed_val(s);
        check_eq("c_reseed_valid", 64'(vld_c), 64'd0);
        check_eq("c_reseed_ready", 64'(sr_c), 64'd1);
        check_eq("c_reseed_rnd", 64'(rnd_c), 64'(exp_c()));
        s = $urandom;
        seed_c(s, 1'b0);
        mc[1] = seed_val(s);
        wait_c(cyc);
        check_eq("c_rewarm_cycles", 64'(cyc), 64'd3);
        for (int i = 0; i < 3; i++) begin
            mc[0] = xs32(mc[0]);
            mc[1] = xs32(mc[1]);
        end
        check_eq("c_rewarm_rnd", 64'(rnd_c), 64'(exp_c()));

        // ---- final report ----
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
